// File: rtl/peripheral_bridge_pkg.sv
// peripheral_bridge shared types: FSM states, error causes, default window.
package peripheral_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } pb_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_DECODE,
    ERR_SLAVE,
    ERR_TIMEOUT
  } pb_err_t;

  localparam logic [31:0] PB_ADDR_BASE = 32'hE000_0000;
  localparam logic [31:0] PB_ADDR_MASK = 32'hF000_0000;

endpackage

// File: rtl/peripheral_bridge_if.sv
// Cache-side request/response and peripheral-side bus bundles
// for peripheral_bridge.
interface peripheral_bridge_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              START;
  logic              REQ_READY;
  logic [ADDR_W-1:0] ADDRESS;
  logic              WRITE;
  logic [DATA_W-1:0] DATA_IN;
  logic [STRB_W-1:0] WSTRB;
  logic [DATA_W-1:0] DATA_OUT;
  logic              DONE;
  logic              ERROR;
  logic              CACHE_READY_DAT;

  modport master (
    output START, ADDRESS, WRITE, DATA_IN, WSTRB,
    output CACHE_READY_DAT,
    input  REQ_READY, DATA_OUT, DONE, ERROR
  );

  modport slave (
    input  START, ADDRESS, WRITE, DATA_IN, WSTRB,
    input  CACHE_READY_DAT,
    output REQ_READY, DATA_OUT, DONE, ERROR
  );
endinterface

interface peripheral_bridge_peri_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] RD_ADDR_TO_PERI;
  logic              RD_ADDR_TO_PERI_VALID;
  logic              RD_ADDR_TO_PERI_READY;
  logic [ADDR_W-1:0] WR_ADDR_TO_PERI;
  logic [DATA_W-1:0] DATA_TO_PERI;
  logic [STRB_W-1:0] WSTRB_OUT;
  logic              WR_TO_PERI_VALID;
  logic              WR_TO_PERI_READY;
  logic [DATA_W-1:0] DATA_FROM_PERI;
  logic              DATA_FROM_PERI_VALID;
  logic              DATA_FROM_PERI_READY;
  logic              TRANSACTION_COMPLETE_PERI;
  logic              PERI_ERROR;

  modport master (
    output RD_ADDR_TO_PERI, RD_ADDR_TO_PERI_VALID,
    input  RD_ADDR_TO_PERI_READY,
    output WR_ADDR_TO_PERI, DATA_TO_PERI, WSTRB_OUT,
    output WR_TO_PERI_VALID,
    input  WR_TO_PERI_READY,
    input  DATA_FROM_PERI, DATA_FROM_PERI_VALID,
    output DATA_FROM_PERI_READY,
    input  TRANSACTION_COMPLETE_PERI, PERI_ERROR
  );

  modport slave (
    input  RD_ADDR_TO_PERI, RD_ADDR_TO_PERI_VALID,
    output RD_ADDR_TO_PERI_READY,
    input  WR_ADDR_TO_PERI, DATA_TO_PERI, WSTRB_OUT,
    input  WR_TO_PERI_VALID,
    output WR_TO_PERI_READY,
    output DATA_FROM_PERI, DATA_FROM_PERI_VALID,
    input  DATA_FROM_PERI_READY,
    output TRANSACTION_COMPLETE_PERI, PERI_ERROR
  );
endinterface

// File: rtl/peripheral_bridge_timeout_ctr.sv
// Completion watchdog counter: counts while enabled, flags LIMIT-1.
module peri_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + W'(1);
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/peripheral_bridge.sv
// Single-outstanding cache-miss to peripheral-bus bridge.
// Define PERIPHERAL_BRIDGE_TIMEOUT_EN to add the completion watchdog.
module peripheral_bridge
  import peripheral_bridge_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(PB_ADDR_BASE),
  parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(PB_ADDR_MASK),
  parameter int              TIMEOUT_CYC = 1024
) (
  input logic CLK,
  input logic RESETN,
  peripheral_bridge_cache_if.slave cache,
  peripheral_bridge_peri_if.master peri
);
  localparam int STRB_W = DATA_W / 8;

  pb_state_t state_q, state_d;
  pb_err_t   cause_q;

  logic              req_ready_q, done_q;
  logic [DATA_W-1:0] data_out_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              rd_valid_q, wr_valid_q, dfp_ready_q;
  logic              wr_q, addr_ok, data_ok, cmp_ok, slv_err;

  logic accept, in_win, busy, tmo;
  logic addr_hs, data_hs, cmp_hs;
  logic addr_n, data_n, cmp_n;

  assign in_win = (cache.ADDRESS & ADDR_MASK) == ADDR_BASE;
  assign accept = (state_q == ST_IDLE) && req_ready_q
                  && cache.START;
  assign busy   = (state_q == ST_ISSUE)
                  || (state_q == ST_WAIT);

  assign addr_hs = busy &&
    ((rd_valid_q && peri.RD_ADDR_TO_PERI_READY) ||
     (wr_valid_q && peri.WR_TO_PERI_READY));
  assign data_hs = busy && dfp_ready_q
                   && peri.DATA_FROM_PERI_VALID;
  assign cmp_hs  = busy && peri.TRANSACTION_COMPLETE_PERI;

  // Same-cycle handshakes count, so the fast path skips WAIT.
  assign addr_n = addr_ok || addr_hs;
  assign data_n = data_ok || data_hs || wr_q;
  assign cmp_n  = cmp_ok || cmp_hs;

`ifdef PERIPHERAL_BRIDGE_TIMEOUT_EN
  logic expired;

  peri_timeout_ctr #(
    .LIMIT(TIMEOUT_CYC)
  ) u_tmo (
    .clk    (CLK),
    .rst_n  (RESETN),
    .clear  (!busy),
    .en     (busy),
    .expired(expired)
  );

  assign tmo = busy && expired;
`else
  assign tmo = 1'b0 && (TIMEOUT_CYC >= 2);
`endif

  always_ff @(posedge CLK) begin
    if (!RESETN)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (accept)
          state_d = in_win ? ST_ISSUE : ST_RESP;
      ST_ISSUE:
        if (tmo || (addr_n && data_n && cmp_n))
          state_d = ST_RESP;
        else if (addr_n)
          state_d = ST_WAIT;
      ST_WAIT:
        if (tmo || (data_n && cmp_n))
          state_d = ST_RESP;
      ST_RESP:
        if (cache.CACHE_READY_DAT)
          state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      data_out_q  <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wstrb_q     <= '0;
      rd_valid_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      dfp_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_ok     <= 1'b0;
      data_ok     <= 1'b0;
      cmp_ok      <= 1'b0;
      slv_err     <= 1'b0;
      cause_q     <= ERR_NONE;
    end else begin
      req_ready_q <= (state_d == ST_IDLE);
      done_q      <= (state_d == ST_RESP);

      if (accept) begin
        wr_q       <= cache.WRITE;
        addr_ok    <= 1'b0;
        data_ok    <= 1'b0;
        cmp_ok     <= 1'b0;
        slv_err    <= 1'b0;
        data_out_q <= '0;
        if (!in_win) begin
          cause_q <= ERR_DECODE;
        end else if (cache.WRITE) begin
          wr_addr_q  <= cache.ADDRESS;
          wr_data_q  <= cache.DATA_IN;
          wstrb_q    <= cache.WSTRB;
          wr_valid_q <= 1'b1;
        end else begin
          rd_addr_q   <= cache.ADDRESS;
          rd_valid_q  <= 1'b1;
          dfp_ready_q <= 1'b1;
        end
      end

      if (addr_hs) begin
        rd_valid_q <= 1'b0;
        wr_valid_q <= 1'b0;
        addr_ok    <= 1'b1;
      end
      if (data_hs) begin
        data_out_q  <= peri.DATA_FROM_PERI;
        dfp_ready_q <= 1'b0;
        data_ok     <= 1'b1;
      end
      if (cmp_hs) begin
        cmp_ok <= 1'b1;
        if (peri.PERI_ERROR)
          slv_err <= 1'b1;
      end

      if (busy && (state_d == ST_RESP)) begin
        if (tmo)
          cause_q <= ERR_TIMEOUT;
        else if (slv_err || (cmp_hs && peri.PERI_ERROR))
          cause_q <= ERR_SLAVE;
        else
          cause_q <= ERR_NONE;
      end

      // Watchdog abort overrides any same-cycle handshake.
      if (tmo) begin
        rd_valid_q  <= 1'b0;
        wr_valid_q  <= 1'b0;
        dfp_ready_q <= 1'b0;
        data_out_q  <= '0;
      end

      if ((state_q == ST_RESP) && cache.CACHE_READY_DAT)
        cause_q <= ERR_NONE;
    end
  end

  assign cache.REQ_READY = req_ready_q;
  assign cache.DONE      = done_q;
  assign cache.ERROR     = |cause_q;
  assign cache.DATA_OUT  = data_out_q;

  assign peri.RD_ADDR_TO_PERI       = rd_addr_q;
  assign peri.RD_ADDR_TO_PERI_VALID = rd_valid_q;
  assign peri.WR_ADDR_TO_PERI       = wr_addr_q;
  assign peri.DATA_TO_PERI          = wr_data_q;
  assign peri.WSTRB_OUT             = wstrb_q;
  assign peri.WR_TO_PERI_VALID      = wr_valid_q;
  assign peri.DATA_FROM_PERI_READY  = dfp_ready_q;

endmodule

// File: tb/tb_peripheral_bridge.sv
// Directed self-checking bench for peripheral_bridge.
// Covers PERIPHERAL_BRIDGE_TIMEOUT_EN both defined and undefined.
module tb_peripheral_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  peripheral_bridge_cache_if #(.ADDR_W(32), .DATA_W(32)) cache();
  peripheral_bridge_peri_if  #(.ADDR_W(32), .DATA_W(32)) peri();

  peripheral_bridge #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT_CYC(16)
  ) dut (
    .CLK   (clk),
    .RESETN(rst_n),
    .cache (cache),
    .peri  (peri)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    peri.RD_ADDR_TO_PERI_READY     = 1'b0;
    peri.WR_TO_PERI_READY          = 1'b0;
    peri.DATA_FROM_PERI            = '0;
    peri.DATA_FROM_PERI_VALID      = 1'b0;
    peri.TRANSACTION_COMPLETE_PERI = 1'b0;
    peri.PERI_ERROR                = 1'b0;
  endtask

  task automatic fast_slave(input logic [31:0] d);
    peri.RD_ADDR_TO_PERI_READY     = 1'b1;
    peri.DATA_FROM_PERI            = d;
    peri.DATA_FROM_PERI_VALID      = 1'b1;
    peri.TRANSACTION_COMPLETE_PERI = 1'b1;
  endtask

  // Issues START in the current cycle; returns in cycle 1.
  task automatic req(input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!cache.REQ_READY && n < 20) begin
      step();
      n++;
    end
    check("req_ready", cache.REQ_READY, 1);
    cache.START   = 1'b1;
    cache.ADDRESS = a;
    cache.WRITE   = w;
    cache.DATA_IN = d;
    cache.WSTRB   = s;
    step();
    cache.START = 1'b0;
    cache.WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok;
    cache.START           = 1'b0;
    cache.ADDRESS         = '0;
    cache.WRITE           = 1'b0;
    cache.DATA_IN         = '0;
    cache.WSTRB           = '0;
    cache.CACHE_READY_DAT = 1'b1;
    idle_bus();

    repeat (3) step();
    check("rst_done", cache.DONE, 0);
    check("rst_error", cache.ERROR, 0);
    check("rst_req_ready", cache.REQ_READY, 0);
    check("rst_rvalid", peri.RD_ADDR_TO_PERI_VALID, 0);
    check("rst_wvalid", peri.WR_TO_PERI_VALID, 0);
    check("rst_dready", peri.DATA_FROM_PERI_READY, 0);
    check("rst_dout", cache.DATA_OUT, 0);
    check("rst_waddr", peri.WR_ADDR_TO_PERI, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_req_ready", cache.REQ_READY, 1);

    // fastest read
    req(32'hE000_0010, 1'b0, '0, '0);
    check("t1_rvalid", peri.RD_ADDR_TO_PERI_VALID, 1);
    check("t1_raddr", peri.RD_ADDR_TO_PERI, 32'hE000_0010);
    check("t1_dready", peri.DATA_FROM_PERI_READY, 1);
    check("t1_req_ready", cache.REQ_READY, 0);
    check("t1_done_c1", cache.DONE, 0);
    fast_slave(32'hCAFE_F00D);
    step();
    idle_bus();
    check("t1_done", cache.DONE, 1);
    check("t1_dout", cache.DATA_OUT, 32'hCAFE_F00D);
    check("t1_error", cache.ERROR, 0);
    check("t1_rvalid_drop", peri.RD_ADDR_TO_PERI_VALID, 0);
    step();
    check("t1_done_fall", cache.DONE, 0);
    check("t1_req_ready_back", cache.REQ_READY, 1);

    // out-of-window read
    req(32'h8000_0000, 1'b0, '0, '0);
    check("t3_done", cache.DONE, 1);
    check("t3_error", cache.ERROR, 1);
    check("t3_dout", cache.DATA_OUT, 0);
    check("t3_rvalid", peri.RD_ADDR_TO_PERI_VALID, 0);
    check("t3_wvalid", peri.WR_TO_PERI_VALID, 0);
    step();
    check("t3_done_fall", cache.DONE, 0);
    check("t3_error_fall", cache.ERROR, 0);

    // write with WR_TO_PERI_READY delayed 5 cycles
    req(32'hE000_0004, 1'b1, 32'h1234_5678, 4'b0011);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ok &= peri.WR_TO_PERI_VALID === 1'b1;
      ok &= peri.WR_ADDR_TO_PERI === 32'hE000_0004;
      ok &= peri.DATA_TO_PERI === 32'h1234_5678;
      ok &= peri.WSTRB_OUT === 4'b0011;
      ok &= peri.RD_ADDR_TO_PERI_VALID === 1'b0;
      ok &= cache.DONE === 1'b0;
      step();
    end
    check("t2_hold_stable", ok, 1);
    check("t2_wvalid_c6", peri.WR_TO_PERI_VALID, 1);
    peri.WR_TO_PERI_READY = 1'b1;
    step();
    peri.WR_TO_PERI_READY = 1'b0;
    check("t2_wvalid_drop", peri.WR_TO_PERI_VALID, 0);
    check("t2_no_done_yet", cache.DONE, 0);
    peri.TRANSACTION_COMPLETE_PERI = 1'b1;
    step();
    idle_bus();
    check("t2_done", cache.DONE, 1);
    check("t2_error", cache.ERROR, 0);
    step();
    check("t2_done_fall", cache.DONE, 0);

    // slave error completion before the address handshake
    req(32'hE000_0020, 1'b0, '0, '0);
    peri.TRANSACTION_COMPLETE_PERI = 1'b1;
    peri.PERI_ERROR                = 1'b1;
    step();
    idle_bus();
    check("t4_no_done_c2", cache.DONE, 0);
    check("t4_rvalid_c2", peri.RD_ADDR_TO_PERI_VALID, 1);
    step();
    peri.RD_ADDR_TO_PERI_READY = 1'b1;
    step();
    peri.RD_ADDR_TO_PERI_READY = 1'b0;
    check("t4_rvalid_drop", peri.RD_ADDR_TO_PERI_VALID, 0);
    check("t4_no_done_c4", cache.DONE, 0);
    peri.DATA_FROM_PERI       = 32'h5555_AAAA;
    peri.DATA_FROM_PERI_VALID = 1'b1;
    step();
    check("t4_done", cache.DONE, 1);
    check("t4_error", cache.ERROR, 1);
    check("t4_dout", cache.DATA_OUT, 32'h5555_AAAA);
    check("t4_dready_off", peri.DATA_FROM_PERI_READY, 0);
    peri.DATA_FROM_PERI = 32'h7777_7777;
    step();
    idle_bus();
    check("t4_done_fall", cache.DONE, 0);
    check("t4_extra_beat", cache.DATA_OUT, 32'h5555_AAAA);

    // DONE held by cache back-pressure; START ignored meanwhile
    cache.CACHE_READY_DAT = 1'b0;
    req(32'hE000_0030, 1'b0, '0, '0);
    fast_slave(32'h1111_2222);
    step();
    idle_bus();
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ok &= cache.DONE === 1'b1;
      ok &= cache.REQ_READY === 1'b0;
      ok &= peri.WR_TO_PERI_VALID === 1'b0;
      ok &= peri.RD_ADDR_TO_PERI_VALID === 1'b0;
      ok &= cache.DATA_OUT === 32'h1111_2222;
      if (i == 3) begin
        cache.START   = 1'b1;
        cache.WRITE   = 1'b1;
        cache.ADDRESS = 32'hE000_0040;
      end
      if (i == 9)
        cache.CACHE_READY_DAT = 1'b1;
      step();
      cache.START = 1'b0;
      cache.WRITE = 1'b0;
    end
    check("t5_hold", ok, 1);
    check("t5_done_fall", cache.DONE, 0);
    check("t5_req_ready", cache.REQ_READY, 1);
    req(32'hE000_0070, 1'b0, '0, '0);
    check("t5_next_rvalid", peri.RD_ADDR_TO_PERI_VALID, 1);
    check("t5_next_raddr", peri.RD_ADDR_TO_PERI, 32'hE000_0070);
    fast_slave(32'h0BAD_BEEF);
    step();
    idle_bus();
    check("t5_next_done", cache.DONE, 1);
    check("t5_next_dout", cache.DATA_OUT, 32'h0BAD_BEEF);
    step();

    // silent slave
    req(32'hE000_0050, 1'b0, '0, '0);
    ok = 1'b1;
`ifdef PERIPHERAL_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      ok &= cache.DONE === 1'b0;
      step();
    end
    check("t6_no_early_done", ok, 1);
    check("t6_done", cache.DONE, 1);
    check("t6_error", cache.ERROR, 1);
    check("t6_dout", cache.DATA_OUT, 0);
    check("t6_rvalid", peri.RD_ADDR_TO_PERI_VALID, 0);
    check("t6_dready", peri.DATA_FROM_PERI_READY, 0);
    fast_slave(32'hFFFF_FFFF);
    step();
    idle_bus();
    check("t6_done_fall", cache.DONE, 0);
    check("t6_req_ready", cache.REQ_READY, 1);
    check("t6_late_ignored", cache.DATA_OUT, 0);
`else
    for (int i = 0; i < 30; i++) begin
      ok &= cache.DONE === 1'b0;
      ok &= peri.RD_ADDR_TO_PERI_VALID === 1'b1;
      step();
    end
    check("t6_waits", ok, 1);
    fast_slave(32'h600D_0001);
    step();
    idle_bus();
    check("t6_done", cache.DONE, 1);
    check("t6_error", cache.ERROR, 0);
    check("t6_dout", cache.DATA_OUT, 32'h600D_0001);
    step();
`endif

    // reset while in WAIT
    req(32'hE000_0060, 1'b0, '0, '0);
    peri.RD_ADDR_TO_PERI_READY = 1'b1;
    step();
    peri.RD_ADDR_TO_PERI_READY = 1'b0;
    check("t7_wait_rvalid", peri.RD_ADDR_TO_PERI_VALID, 0);
    check("t7_wait_dready", peri.DATA_FROM_PERI_READY, 1);
    check("t7_wait_done", cache.DONE, 0);
    rst_n = 1'b0;
    step();
    check("t7_rst_dready", peri.DATA_FROM_PERI_READY, 0);
    check("t7_rst_rvalid", peri.RD_ADDR_TO_PERI_VALID, 0);
    check("t7_rst_wvalid", peri.WR_TO_PERI_VALID, 0);
    check("t7_rst_done", cache.DONE, 0);
    check("t7_rst_req_ready", cache.REQ_READY, 0);
    rst_n = 1'b1;
    fast_slave(32'hDEAD_0000);
    step();
    idle_bus();
    check("t7_req_ready", cache.REQ_READY, 1);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ok &= cache.DONE === 1'b0;
      step();
    end
    check("t7_no_done", ok, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
